// File: rtl/apb_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : apb_master_if                                                 |
// | Summary  : command, response and APB signal bundle for apb_master        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface apb_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic [STRB_WIDTH-1:0] cmd_strb;

   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_err;
   logic                  resp_timeout;

   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PSELx;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [STRB_WIDTH-1:0] PSTRB;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
      output cmd_ready,
      output resp_valid, resp_rdata, resp_err, resp_timeout,
      input  resp_ready,
      output PADDR, PSELx, PENABLE, PWRITE, PWDATA, PSTRB,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
      input  cmd_ready,
      input  resp_valid, resp_rdata, resp_err, resp_timeout,
      output resp_ready,
      input  PADDR, PSELx, PENABLE, PWRITE, PWDATA, PSTRB,
      output PRDATA, PREADY, PSLVERR
   );
endinterface
`default_nettype wire

// File: rtl/apb_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : apb_master                                                    |
// | Summary  : single-outstanding command/response to APB bridge, timeout    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module apb_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input wire           PCLK,
   input wire           PRESETn,
   apb_master_if.master bus
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int CNT_WIDTH  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_WIDTH'(TIMEOUT - 1) : '0;
   localparam bit TIMEOUT_EN = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   state_e                state_q,        state_d;
   logic                  cmd_ready_q,    cmd_ready_d;
   logic                  psel_q,         psel_d;
   logic                  penable_q,      penable_d;
   logic                  pwrite_q,       pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q,        paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q,       pwdata_d;
   logic [STRB_WIDTH-1:0] pstrb_q,        pstrb_d;
   logic                  resp_valid_q,   resp_valid_d;
   logic [DATA_WIDTH-1:0] resp_rdata_q,   resp_rdata_d;
   logic                  resp_err_q,     resp_err_d;
   logic                  resp_timeout_q, resp_timeout_d;
   logic [CNT_WIDTH-1:0]  cnt_q,          cnt_d;

   always_comb begin
      state_d        = state_q;
      cmd_ready_d    = cmd_ready_q;
      psel_d         = psel_q;
      penable_d      = penable_q;
      pwrite_d       = pwrite_q;
      paddr_d        = paddr_q;
      pwdata_d       = pwdata_q;
      pstrb_d        = pstrb_q;
      resp_valid_d   = resp_valid_q;
      resp_rdata_d   = resp_rdata_q;
      resp_err_d     = resp_err_q;
      resp_timeout_d = resp_timeout_q;
      cnt_d          = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               // Reads carry no write data or strobes onto the bus.
               paddr_d     = bus.cmd_addr;
               pwrite_d    = bus.cmd_write;
               pwdata_d    = bus.cmd_write ? bus.cmd_wdata : '0;
               pstrb_d     = bus.cmd_write ? bus.cmd_strb  : '0;
               psel_d      = 1'b1;
               cmd_ready_d = 1'b0;
               state_d     = ST_SETUP;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (bus.PREADY) begin
               resp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
               resp_err_d     = bus.PSLVERR;
               resp_timeout_d = 1'b0;
               psel_d         = 1'b0;
               penable_d      = 1'b0;
               resp_valid_d   = 1'b1;
               state_d        = ST_RESP;
            end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
               // Last permitted wait cycle with no PREADY: abandon the slave.
               resp_rdata_d   = '0;
               resp_err_d     = 1'b1;
               resp_timeout_d = 1'b1;
               psel_d         = 1'b0;
               penable_d      = 1'b0;
               resp_valid_d   = 1'b1;
               state_d        = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               cmd_ready_d  = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q        <= ST_IDLE;
         cmd_ready_q    <= 1'b1;
         psel_q         <= 1'b0;
         penable_q      <= 1'b0;
         pwrite_q       <= 1'b0;
         paddr_q        <= '0;
         pwdata_q       <= '0;
         pstrb_q        <= '0;
         resp_valid_q   <= 1'b0;
         resp_rdata_q   <= '0;
         resp_err_q     <= 1'b0;
         resp_timeout_q <= 1'b0;
         cnt_q          <= '0;
      end else begin
         state_q        <= state_d;
         cmd_ready_q    <= cmd_ready_d;
         psel_q         <= psel_d;
         penable_q      <= penable_d;
         pwrite_q       <= pwrite_d;
         paddr_q        <= paddr_d;
         pwdata_q       <= pwdata_d;
         pstrb_q        <= pstrb_d;
         resp_valid_q   <= resp_valid_d;
         resp_rdata_q   <= resp_rdata_d;
         resp_err_q     <= resp_err_d;
         resp_timeout_q <= resp_timeout_d;
         cnt_q          <= cnt_d;
      end
   end

   assign bus.cmd_ready    = cmd_ready_q;
   assign bus.PSELx        = psel_q;
   assign bus.PENABLE      = penable_q;
   assign bus.PWRITE       = pwrite_q;
   assign bus.PADDR        = paddr_q;
   assign bus.PWDATA       = pwdata_q;
   assign bus.PSTRB        = pstrb_q;
   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp_rdata   = resp_rdata_q;
   assign bus.resp_err     = resp_err_q;
   assign bus.resp_timeout = resp_timeout_q;
endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_apb_master                                                 |
// | Summary  : scoreboard bench for apb_master with randomized slave waits   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_apb_master;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 16;

   typedef struct packed {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] strb;
      int            waits;
      logic          slverr;
      logic [DW-1:0] rdata;
   } txn_t;

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          err;
      logic          to;
   } resp_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          write;
      logic [DW-1:0] wdata;
      logic [SW-1:0] strb;
      int            len;
   } xfer_t;

   logic PCLK    = 1'b0;
   logic PRESETn = 1'b0;
   always #5 PCLK = ~PCLK;

   apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus)
   );

   int      checks   = 0;
   int      failures = 0;
   bit      mon_en   = 1'b0;
   bit      rr_random = 1'b0;
   resp_t   resp_q[$];
   xfer_t   xfer_q[$];
   txn_t    plan_q[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name, input string why);
      checks++;
      failures++;
      $display("FAIL %s: %s t=%0t", name, why, $time);
   endtask

   // Reference model: what the transfer should look like from the outside.
   function automatic resp_t model_resp(input txn_t t);
      resp_t r;
      if (TO != 0 && t.waits >= TO) begin
         r.rdata = '0; r.err = 1'b1; r.to = 1'b1;
      end else begin
         r.rdata = t.write ? '0 : t.rdata; r.err = t.slverr; r.to = 1'b0;
      end
      return r;
   endfunction

   function automatic xfer_t model_xfer(input txn_t t);
      xfer_t x;
      x.addr  = t.addr;
      x.write = t.write;
      x.wdata = t.write ? t.wdata : '0;
      x.strb  = t.write ? t.strb  : '0;
      x.len   = (TO != 0 && t.waits >= TO) ? TO : t.waits + 1;
      return x;
   endfunction

   function automatic txn_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                               input logic [SW-1:0] s, input int wt, input logic e,
                               input logic [DW-1:0] rd);
      txn_t t;
      t.write = w; t.addr = a; t.wdata = wd; t.strb = s; t.waits = wt; t.slverr = e; t.rdata = rd;
      return t;
   endfunction

   // Called on a negedge; returns on the negedge after the handshake edge.
   task automatic issue(input txn_t t);
      int n = 0;
      bus.cmd_write = t.write;
      bus.cmd_addr  = t.addr;
      bus.cmd_wdata = t.wdata;
      bus.cmd_strb  = t.strb;
      bus.cmd_valid = 1'b1;
      while (bus.cmd_ready !== 1'b1) begin
         @(negedge PCLK);
         n++;
         if (n > 400) begin
            fail_now("cmd_accept", "cmd_ready never returned");
            bus.cmd_valid = 1'b0;
            return;
         end
      end
      plan_q.push_back(t);
      xfer_q.push_back(model_xfer(t));
      resp_q.push_back(model_resp(t));
      @(negedge PCLK);
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = $urandom;
      bus.cmd_wdata = $urandom;
      check("setup_after_handshake", {bus.PSELx, bus.PENABLE, bus.cmd_ready}, 3'b100);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(resp_q.size() == 0 && bus.cmd_ready === 1'b1)) begin
         @(negedge PCLK);
         n++;
         if (n > 400) begin
            fail_now("idle_wait", "response never completed");
            return;
         end
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
      check({tag, "_psel_penable"}, {bus.PSELx, bus.PENABLE}, 2'b00);
      check({tag, "_pwrite"}, bus.PWRITE, 1'b0);
      check({tag, "_paddr"}, bus.PADDR, '0);
      check({tag, "_pwdata"}, bus.PWDATA, '0);
      check({tag, "_pstrb"}, bus.PSTRB, '0);
      check({tag, "_resp_valid"}, bus.resp_valid, 1'b0);
      check({tag, "_resp_fields"}, {bus.resp_rdata, bus.resp_err, bus.resp_timeout}, '0);
   endtask

   // APB slave: waits come from the per-transfer plan; PSLVERR is inverted while not ready.
   initial begin : slave
      txn_t cur;
      int   wait_left;
      cur = '0;
      wait_left = 0;
      bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
      forever begin
         @(negedge PCLK);
         if (bus.PSELx === 1'b1 && bus.PENABLE === 1'b0) begin
            if (plan_q.size() > 0) cur = plan_q.pop_front();
            wait_left    = cur.waits;
            bus.PREADY   = 1'($urandom_range(0, 1));
            bus.PRDATA   = $urandom;
            bus.PSLVERR  = 1'($urandom_range(0, 1));
         end else if (bus.PSELx === 1'b1 && bus.PENABLE === 1'b1) begin
            if (wait_left > 0) begin
               wait_left--;
               bus.PREADY  = 1'b0;
               bus.PRDATA  = $urandom;
               bus.PSLVERR = ~cur.slverr;
            end else begin
               bus.PREADY  = 1'b1;
               bus.PRDATA  = cur.rdata;
               bus.PSLVERR = cur.slverr;
            end
         end else begin
            bus.PREADY  = 1'($urandom_range(0, 1));
            bus.PRDATA  = $urandom;
            bus.PSLVERR = 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin : resp_ready_driver
      bus.resp_ready = 1'b1;
      forever begin
         @(negedge PCLK);
         if (rr_random) bus.resp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // APB monitor: phase order, field stability and ACCESS length.
   initial begin : apb_monitor
      xfer_t cur;
      int    acc;
      logic  prev_psel, prev_setup;
      cur = '0; acc = 0; prev_psel = 1'b0; prev_setup = 1'b0;
      forever begin
         @(negedge PCLK); #1;
         if (mon_en) begin
            if (prev_setup) check("setup_to_access", {bus.PSELx, bus.PENABLE}, 2'b11);
            if (bus.PSELx === 1'b1 && bus.PENABLE === 1'b0) begin
               check("idle_before_setup", prev_psel, 1'b0);
               if (xfer_q.size() == 0) begin
                  fail_now("unexpected_setup", "transfer started with no command");
               end else begin
                  cur = xfer_q.pop_front();
                  check("setup_fields", {bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB},
                        {cur.addr, cur.write, cur.wdata, cur.strb});
               end
               acc = 0;
            end
            if (bus.PSELx === 1'b1 && bus.PENABLE === 1'b1) begin
               acc++;
               check("access_fields_stable", {bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB},
                     {cur.addr, cur.write, cur.wdata, cur.strb});
            end
            if (bus.PSELx === 1'b1) check("cmd_ready_busy", bus.cmd_ready, 1'b0);
            if (bus.PENABLE === 1'b1 && bus.PSELx !== 1'b1) fail_now("penable_without_psel", "PENABLE high while PSELx low");
            if (bus.resp_valid === 1'b1 && prev_psel === 1'b1) check("access_cycles", acc, cur.len);
            prev_setup = (bus.PSELx === 1'b1 && bus.PENABLE === 1'b0);
            prev_psel  = (bus.PSELx === 1'b1);
         end else begin
            prev_setup = 1'b0;
            prev_psel  = 1'b0;
         end
      end
   end

   // Response scoreboard: pops on each resp handshake.
   initial begin : resp_monitor
      resp_t got, held, exp;
      logic  hold, prev_hs;
      hold = 1'b0; prev_hs = 1'b0; held = '0;
      forever begin
         @(negedge PCLK); #1;
         if (mon_en) begin
            if (prev_hs) begin
               check("resp_single_cycle", bus.resp_valid, 1'b0);
               check("cmd_ready_after_resp", bus.cmd_ready, 1'b1);
            end
            prev_hs = 1'b0;
            if (bus.resp_valid === 1'b1) begin
               got = {bus.resp_rdata, bus.resp_err, bus.resp_timeout};
               check("resp_bus_idle", {bus.PSELx, bus.PENABLE, bus.cmd_ready}, 3'b000);
               if (hold) check("resp_stable", got, held);
               if (bus.resp_ready === 1'b1) begin
                  if (resp_q.size() == 0) begin
                     fail_now("unexpected_resp", "response with no outstanding command");
                  end else begin
                     exp = resp_q.pop_front();
                     check("resp_rdata", got.rdata, exp.rdata);
                     check("resp_err", got.err, exp.err);
                     check("resp_timeout", got.to, exp.to);
                  end
                  hold    = 1'b0;
                  prev_hs = 1'b1;
               end else begin
                  hold = 1'b1;
                  held = got;
               end
            end else begin
               hold = 1'b0;
            end
         end else begin
            hold = 1'b0; prev_hs = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int n;
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
      bus.cmd_wdata = '0; bus.cmd_strb = '0;

      PRESETn = 1'b0;
      repeat (3) @(negedge PCLK);
      check_reset_values("reset");
      PRESETn = 1'b1;
      mon_en  = 1'b1;
      @(negedge PCLK);

      // Zero-wait write with cycle-exact latency.
      issue(mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h5555_AAAA));
      @(negedge PCLK);
      check("access_at_n1", {bus.PSELx, bus.PENABLE}, 2'b11);
      check("pwdata_write", bus.PWDATA, 32'hDEAD_BEEF);
      @(negedge PCLK);
      check("resp_valid_at_n2", bus.resp_valid, 1'b1);
      @(negedge PCLK);
      check("cmd_ready_back", bus.cmd_ready, 1'b1);

      issue(mk(1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF, 3, 1'b0, 32'h1234_5678));
      wait_idle();
      issue(mk(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'h3, 0, 1'b1, 32'h0));
      wait_idle();
      issue(mk(1'b1, 32'h0000_0024, 32'hCAFE_0001, 4'hC, 3, 1'b0, 32'h0));
      wait_idle();
      issue(mk(1'b0, 32'h0000_0030, 32'h0, 4'h0, TO - 1, 1'b0, 32'hA5A5_5A5A));
      wait_idle();
      issue(mk(1'b0, 32'h0000_0034, 32'h0, 4'h0, TO, 1'b0, 32'hA5A5_5A5A));
      wait_idle();
      issue(mk(1'b1, 32'h0000_0038, 32'h1111_2222, 4'hF, 40, 1'b0, 32'h0));
      wait_idle();

      // Response backpressure for 5 cycles.
      bus.resp_ready = 1'b0;
      issue(mk(1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 1'b0, 32'h7777_8888));
      n = 0;
      while (bus.resp_valid !== 1'b1 && n < 50) begin @(negedge PCLK); n++; end
      check("bp_resp_arrived", bus.resp_valid, 1'b1);
      repeat (5) begin
         check("bp_hold", {bus.resp_valid, bus.cmd_ready, bus.PSELx}, 3'b100);
         @(negedge PCLK);
      end
      bus.resp_ready = 1'b1;
      wait_idle();

      // Reset in the middle of a wait-stated read.
      issue(mk(1'b0, 32'h0000_0050, 32'h0, 4'h0, 10, 1'b0, 32'h9999_0000));
      repeat (4) @(negedge PCLK);
      check("in_access_before_reset", {bus.PSELx, bus.PENABLE}, 2'b11);
      PRESETn = 1'b0;
      resp_q.delete();
      @(negedge PCLK);
      PRESETn = 1'b1;
      check_reset_values("midreset");
      repeat (3) begin
         @(negedge PCLK);
         check("no_resp_after_reset", {bus.resp_valid, bus.PSELx}, 2'b00);
      end
      issue(mk(1'b1, 32'h0000_0060, 32'h0F0F_F0F0, 4'h5, 1, 1'b0, 32'h0));
      wait_idle();

      // Randomized traffic, next command presented while the previous is in flight.
      rr_random = 1'b1;
      for (int i = 0; i < 40; i++) begin
         txn_t t;
         int   r;
         r = $urandom_range(0, 9);
         t.write  = 1'($urandom_range(0, 1));
         t.addr   = $urandom;
         t.wdata  = $urandom;
         t.strb   = SW'($urandom);
         t.slverr = 1'($urandom_range(0, 1));
         t.rdata  = $urandom;
         if (r < 6)      t.waits = $urandom_range(0, 3);
         else if (r < 8) t.waits = $urandom_range(4, TO - 2);
         else            t.waits = $urandom_range(TO - 1, TO + 4);
         issue(t);
      end
      wait_idle();
      rr_random = 1'b0;
      bus.resp_ready = 1'b1;
      repeat (3) @(negedge PCLK);
      check("resp_queue_drained", resp_q.size(), 0);
      check("xfer_queue_drained", xfer_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
